// File: rtl/audio_sample_feeder.sv
// audio_sample_feeder: buffers stereo samples in a 2-entry FIFO and paces them out on fractional-rate ce/sample_ce strobes
module audio_sample_feeder #(
  parameter int CLK_RATE    = 24576000,
  parameter int SAMPLE_RATE = 48000,
  parameter int STEREO      = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rate_sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_l,
  input  logic signed [15:0] in_r,
  output logic               ce_out,
  output logic               sample_ce_out,
  output logic signed [15:0] out_l,
  output logic signed [15:0] out_r,
  output logic [7:0]         underrun_cnt
);
  localparam logic [31:0] BASE_STEP = 32'(SAMPLE_RATE * ((STEREO != 0) ? 2 : 1));
  localparam logic [31:0] CLK_R     = 32'(CLK_RATE);
  logic [31:0] r_acc;
  logic        r_ce;
  logic        r_phase;
  logic [31:0] r_mem [0:1];
  logic        r_wr;
  logic        r_rd;
  logic [1:0]  r_cnt;
  logic [15:0] r_out_l;
  logic [15:0] r_out_r;
  logic [7:0]  r_und;
  logic [31:0] w_step;
  logic [32:0] w_sum;
  logic        w_hit;
  logic        w_push;
  logic        w_pop;
  logic        w_under;
  always_comb begin
    w_step  = rate_sel ? {BASE_STEP[30:0], 1'b0} : BASE_STEP;
    w_sum   = {1'b0, r_acc} + {1'b0, w_step};
    w_hit   = w_sum >= {1'b0, CLK_R};
    in_ready = r_cnt != 2'd2;
    w_push  = in_valid & in_ready;
    w_pop   = sample_ce_out & (r_cnt != 2'd0);
    w_under = sample_ce_out & (r_cnt == 2'd0);
  end
  assign ce_out        = r_ce;
  // In stereo the ce alternates L/R; a new pair is due after the second of each
  assign sample_ce_out = (STEREO != 0) ? (r_ce & r_phase) : r_ce;
  assign out_l         = r_out_l;
  assign out_r         = r_out_r;
  assign underrun_cnt  = r_und;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc   <= '0;
      r_ce    <= 1'b0;
      r_phase <= 1'b0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_cnt   <= '0;
      r_out_l <= '0;
      r_out_r <= '0;
      r_und   <= '0;
    end else begin
      r_acc   <= r_acc + w_step - (w_hit ? CLK_R : 32'd0);
      r_ce    <= w_hit;
      r_phase <= r_phase ^ r_ce;
      r_wr    <= r_wr ^ w_push;
      r_rd    <= r_rd ^ w_pop;
      r_cnt   <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop) {r_out_l, r_out_r} <= r_mem[r_rd];
      if (w_under && r_und != 8'hFF) r_und <= r_und + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {in_l, in_r};
  end
endmodule

// File: tb/tb_audio_sample_feeder.sv
// tb_audio_sample_feeder: strobe-timing vector table plus scoreboarded FIFO/underrun/reset sequences
module tb_audio_sample_feeder;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic rate_sel = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [15:0] in_l = '0;
  logic signed [15:0] in_r = '0;
  logic ce_out, sample_ce_out;
  logic signed [15:0] out_l, out_r;
  logic [7:0] underrun_cnt;
  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [31:0] exp_out = '0;
  int exp_und = 0;
  typedef struct {
    bit rs;
    int cycles;
    int first;
    int n_ce;
    int n_sce;
    int gmin;
    int gmax;
  } vec_t;
  vec_t vt[3];
  always #5 clk = ~clk;
  audio_sample_feeder #(.CLK_RATE(100), .SAMPLE_RATE(10), .STEREO(1)) dut (
    .clk(clk), .reset_n(reset_n), .rate_sel(rate_sel), .in_valid(in_valid),
    .in_ready(in_ready), .in_l(in_l), .in_r(in_r), .ce_out(ce_out),
    .sample_ce_out(sample_ce_out), .out_l(out_l), .out_r(out_r),
    .underrun_cnt(underrun_cnt)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic clear_model();
    q.delete();
    exp_out = '0;
    exp_und = 0;
  endtask
  task automatic tick();
    bit push, pop;
    push = in_valid && (q.size() != 2);
    pop = sample_ce_out;
    @(posedge clk);
    #1;
    if (pop) begin
      if (q.size() != 0) exp_out = q.pop_front();
      else if (exp_und != 255) exp_und++;
    end
    if (push) q.push_back({in_l, in_r});
    if (pop) begin
      chk("sb_out", {out_l, out_r}, exp_out);
      chk("sb_underrun", underrun_cnt, exp_und);
    end
    if (push || pop) chk("sb_in_ready", in_ready, q.size() != 2);
  endtask
  task automatic do_reset(input bit rs);
    @(negedge clk);
    reset_n = 1'b0;
    in_valid = 1'b0;
    rate_sel = rs;
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic wait_sce();
    int n = 0;
    while (!sample_ce_out && n < 40) begin
      tick();
      n++;
    end
    if (!sample_ce_out) chk("sce_timeout", sample_ce_out, 1);
  endtask
  task automatic drive(input logic v, input logic [15:0] l, input logic [15:0] r);
    in_valid = v;
    in_l = l;
    in_r = r;
  endtask
  initial begin
    int first, last, nce, nsce, gmin, gmax, bad, n;
    vt[0] = '{0, 1000, 5, 200, 100, 5, 5};
    vt[1] = '{1, 500, 3, 200, 100, 2, 3};
    vt[2] = '{0, 100, 5, 20, 10, 5, 5};
    #1 reset_n = 1'b0;
    #12;
    chk("rst_ce", ce_out, 0);
    chk("rst_sce", sample_ce_out, 0);
    chk("rst_out", {out_l, out_r}, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_und", underrun_cnt, 0);
    foreach (vt[k]) begin
      do_reset(vt[k].rs);
      first = -1; last = -1; nce = 0; nsce = 0; gmin = 1000000; gmax = 0; bad = 0;
      for (int t = 1; t <= vt[k].cycles; t++) begin
        tick();
        if (sample_ce_out && !ce_out) bad++;
        if (ce_out) begin
          nce++;
          if (sample_ce_out) nsce++;
          if (sample_ce_out != (nce % 2 == 0)) bad++;
          if (last < 0) first = t;
          else begin
            gmin = (t - last < gmin) ? t - last : gmin;
            gmax = (t - last > gmax) ? t - last : gmax;
          end
          last = t;
        end
      end
      chk($sformatf("v%0d_first", k), first, vt[k].first);
      chk($sformatf("v%0d_nce", k), nce, vt[k].n_ce);
      chk($sformatf("v%0d_nsce", k), nsce, vt[k].n_sce);
      chk($sformatf("v%0d_gmin", k), gmin, vt[k].gmin);
      chk($sformatf("v%0d_gmax", k), gmax, vt[k].gmax);
      chk($sformatf("v%0d_sce_pattern", k), bad, 0);
    end
    do_reset(0);
    drive(1, 16'h1234, 16'hABCD);
    tick();
    drive(1, 16'h7FFF, 16'h8000);
    tick();
    tick();
    chk("full_ready", in_ready, 0);
    drive(0, 16'h0, 16'h0);
    wait_sce();
    tick();
    chk("pop1_out", {out_l, out_r}, 32'h1234ABCD);
    chk("pop1_ready", in_ready, 1);
    wait_sce();
    tick();
    chk("pop2_out", {out_l, out_r}, 32'h7FFF8000);
    chk("pop2_ready", in_ready, 1);
    do_reset(0);
    drive(1, 16'h0005, 16'hFFFB);
    tick();
    drive(0, 16'h0, 16'h0);
    for (int i = 0; i < 300; i++) begin
      wait_sce();
      tick();
    end
    chk("hold_out", {out_l, out_r}, 32'h0005FFFB);
    chk("und_sat", underrun_cnt, 255);
    do_reset(0);
    drive(1, 16'h1111, 16'h2222);
    tick();
    drive(0, 16'h0, 16'h0);
    wait_sce();
    drive(1, 16'h3333, 16'h4444);
    tick();
    drive(0, 16'h0, 16'h0);
    chk("sim_out_old", {out_l, out_r}, 32'h11112222);
    chk("sim_ready", in_ready, 1);
    wait_sce();
    tick();
    chk("sim_out_new", {out_l, out_r}, 32'h33334444);
    chk("sim_und", underrun_cnt, 0);
    do_reset(1);
    drive(1, 16'h0101, 16'h0202);
    tick();
    drive(0, 16'h0, 16'h0);
    wait_sce();
    tick();
    wait_sce();
    drive(1, 16'h0303, 16'h0404);
    tick();
    drive(1, 16'h0505, 16'h0606);
    tick();
    drive(0, 16'h0, 16'h0);
    n = 0;
    while (!ce_out && n < 20) begin
      tick();
      n++;
    end
    chk("pre_ce", ce_out, 1);
    chk("pre_ready", in_ready, 0);
    chk("pre_out", {out_l, out_r}, 32'h01010202);
    chk("pre_und", underrun_cnt, 1);
    #2 reset_n = 1'b0;
    clear_model();
    #1;
    chk("arst_ce", ce_out, 0);
    chk("arst_sce", sample_ce_out, 0);
    chk("arst_out", {out_l, out_r}, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_und", underrun_cnt, 0);
    @(negedge clk);
    rate_sel = 1'b0;
    reset_n = 1'b1;
    n = 0;
    while (!ce_out && n < 20) begin
      tick();
      n++;
    end
    chk("arst_first_ce", n, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/audio_sample_feeder.md
Name: audio_sample_feeder

Overview:
- Upstream feeder for the 2-channel IIR filter and DC blocker chain.
- Accepts signed 16-bit stereo samples from a core over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Generates the filter's ce strobe (2x sample rate in stereo, 1x in mono) and its sample_ce strobe from a fractional accumulator.
- Presents a zero-order-held sample pair that changes only on sample_ce.

Parameters:
- CLK_RATE, 24576000, clk frequency in Hz; must be >= 2 * ce step (see Behaviour).
- SAMPLE_RATE, 48000, base output sample rate in Hz.
- STEREO, 1, 1: ce runs at 2x sample rate; 0: ce equals sample rate.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rate_sel  in  1  0: SAMPLE_RATE; 1: 2*SAMPLE_RATE (96 kHz mode)
- in_valid  in  1  upstream sample pair valid
- in_ready  out  1  FIFO can accept a pair
- in_l  in  16  signed left sample
- in_r  in  16  signed right sample
- ce_out  out  1  one-clk strobe, filter ce
- sample_ce_out  out  1  one-clk strobe, filter sample_ce
- out_l  out  16  held left sample
- out_r  out  16  held right sample
- underrun_cnt  out  8  saturating count of sample_ce with empty FIFO

Behaviour:
- Reset (async assert, sync release): acc=0, phase=0, FIFO empty, out_l/out_r=0, underrun_cnt=0, ce_out=0, sample_ce_out=0, in_ready=1.
- Step: step = SAMPLE_RATE * (STEREO?2:1) * (rate_sel?2:1). Accumulator width is 32 bits unsigned.
- Each clk: if acc+step >= CLK_RATE, then acc <= acc+step-CLK_RATE and ce_out=1 next cycle; else acc <= acc+step and ce_out=0.
- ce_out is registered and lasts exactly one clk. Never two consecutive ce_out pulses, given the CLK_RATE >= 2*step requirement.
- rate_sel change: takes effect on the next clk's addition. acc is not cleared and phase is not touched.
- Phase:
  - Stereo: phase toggles on every ce_out. sample_ce_out = ce_out on the pulse where phase was 1, i.e. every second ce_out starting with the second after reset.
  - Mono: sample_ce_out = ce_out.
- FIFO: 2 entries of {in_l, in_r}. Push when in_valid & in_ready. in_ready = (count != 2), combinational from count.
- Pop: on the same clk as sample_ce_out is asserted, the head entry is loaded into out_l/out_r. Outputs are visible the clk after the sample_ce_out pulse, which matches the filter's sample_ce registering.
- Pop with FIFO empty:
  - out_l/out_r hold their previous values.
  - underrun_cnt increments, saturating at 255.
- Simultaneous push and pop:
  - count 0: not possible to pop the same-cycle push. The push lands, the output holds, and it counts as an underrun.
  - count 1: pop old head, push new entry, count stays 1.
  - count 2: in_ready=0, pop only, count goes to 1.
- Latency: a pair pushed into an empty FIFO at cycle t appears on out_* after the first sample_ce_out at cycle > t.
- Ordering is strictly FIFO. No sample is dropped or duplicated except hold-on-underrun.
- in_l/in_r are ignored when no push occurs.
- Reset mid-operation: all state is cleared immediately, the FIFO contents are discarded, and the strobes are forced low asynchronously.

Test Plan:
1. CLK_RATE=100, SAMPLE_RATE=10, STEREO=1, rate_sel=0 (step 20), after reset -> ce_out every 5 clks exactly; sample_ce_out on every 2nd ce_out (period 10); no jitter over 1000 clks.
2. Same config, rate_sel=1 (step 40) -> ce_out spacing alternates 3,2,3,2 clks (2 pulses per 5 clks); 200 ce_out in 500 clks; sample_ce_out period 5 on average.
3. Push 0x1234/0xABCD, then 0x7FFF/0x8000, with in_valid held -> in_ready drops after 2 pushes. out_* become 0x1234/0xABCD after the next sample_ce_out, then 0x7FFF/0x8000 after the following one; in_ready returns to 1 after each pop.
4. No pushes for 300 sample_ce_out after one pair 0x0005/0xFFFB -> out holds 0x0005/0xFFFB; underrun_cnt saturates at 255 and does not wrap.
5. FIFO count 1, push on the same clk as sample_ce_out -> count remains 1 and the outputs take the older entry. The new entry emerges at the next sample_ce_out.
6. Assert reset_n low mid-stream with FIFO full and acc nonzero -> strobes go 0, out_*=0, in_ready=1 and underrun_cnt=0 immediately. After release, the first ce_out occurs 5 clks later (config 1).
